register_bank: RTL and testbench

//   Parametrised general-purpose register bank; successor to the single SAP accumulator.

---
 rtl/sap_pkg.sv | 17 +
 rtl/reg_update_unit.sv | 52 +++++
 rtl/register_bank.sv | 65 ++++++
 tb/tb_register_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP register bank: update opcodes and default data width.
package sap_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_CLR  = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_ROR  = 3'b111
  } reg_op_t;

endpackage

// File: rtl/reg_update_unit.sv
// Combinational update for one register: computes result and carry from op, current value and bus.
// Shift/rotate ops exist only when REGISTER_BANK_SHIFT_EN is defined; otherwise they request no write.
module reg_update_unit
  import sap_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  reg_op_t          op_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] bus_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             write_o
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result_o = cur_i;
    carry_o  = 1'b0;
    write_o  = 1'b1;
    case (op_i)
      OP_LOAD: result_o = bus_i;
      OP_CLR:  result_o = '0;
      // Widen by one bit so the top bit is the carry (INC) or borrow (DEC).
      OP_INC:  {carry_o, result_o} = {1'b0, cur_i} + ONE;
      OP_DEC:  {carry_o, result_o} = {1'b0, cur_i} - ONE;
`ifdef REGISTER_BANK_SHIFT_EN
      OP_SHL: begin
        carry_o  = cur_i[WIDTH-1];
        result_o = {cur_i[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_o  = cur_i[0];
        result_o = {1'b0, cur_i[WIDTH-1:1]};
      end
      OP_ROL: begin
        carry_o  = cur_i[WIDTH-1];
        result_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
      end
      OP_ROR: begin
        carry_o  = cur_i[0];
        result_o = {cur_i[0], cur_i[WIDTH-1:1]};
      end
      default: write_o = 1'b0;
`else
      default: write_o = 1'b0;
`endif
    endcase
  end

endmodule

// File: rtl/register_bank.sv
// General-purpose register bank on the shared tri-state w_bus, with zero/carry flags.
// Define REGISTER_BANK_SHIFT_EN to enable SHL/SHR/ROL/ROR; otherwise those ops are no-ops.
module register_bank
  import sap_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             zero,
  output logic             carry,
  inout  wire  [WIDTH-1:0] w_bus
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic             zero_q, carry_q;

  logic             wr_valid, rd_valid;
  logic [WIDTH-1:0] cur_val, rd_val;
  logic [WIDTH-1:0] result_d;
  logic             carry_d, upd_write;

  assign wr_valid = 32'(wr_sel) < NUM_REGS;
  assign rd_valid = 32'(rd_sel) < NUM_REGS;
  assign cur_val  = wr_valid ? regs_q[wr_sel] : '0;
  assign rd_val   = rd_valid ? regs_q[rd_sel] : '0;

  assign w_bus = enable ? rd_val : 'z;

  reg_update_unit #(.WIDTH(WIDTH)) u_update (
    .op_i     (reg_op_t'(op)),
    .cur_i    (cur_val),
    .bus_i    (w_bus),
    .result_o (result_d),
    .carry_o  (carry_d),
    .write_o  (upd_write)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
    end else if (!load && wr_valid && upd_write) begin
      regs_q[wr_sel] <= result_d;
      zero_q         <= (result_d == '0);
      carry_q        <= carry_d;
    end
  end

  assign alu_a = regs_q[0];
  assign alu_b = regs_q[1];
  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank (WIDTH=8, NUM_REGS=4).
module tb_register_bank;

  logic       clk = 1'b0;
  logic       reset, load, enable;
  logic [2:0] op;
  logic [1:0] wr_sel, rd_sel;
  logic [7:0] alu_a, alu_b;
  logic       zero, carry;
  wire  [7:0] w_bus;
  logic [7:0] drv_val;
  logic       drv_en;
  logic [7:0] v;
  int         vectors = 0;
  int         miscompares = 0;

  assign w_bus = drv_en ? drv_val : 'z;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(8), .NUM_REGS(4)) dut (
    .clk(clk), .reset(reset), .load(load), .enable(enable), .op(op),
    .wr_sel(wr_sel), .rd_sel(rd_sel), .alu_a(alu_a), .alu_b(alu_b),
    .zero(zero), .carry(carry), .w_bus(w_bus)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    load = 1'b1; enable = 1'b0; drv_en = 1'b0; op = 3'b000;
  endtask

  // Write via external bus driver into register n
  task automatic ext_load(input logic [1:0] n, input logic [7:0] val);
    drv_en = 1'b1; drv_val = val; enable = 1'b0;
    load = 1'b0; op = 3'b000; wr_sel = n;
    cyc();
    idle();
  endtask

  task automatic do_op(input logic [2:0] o, input logic [1:0] n);
    enable = 1'b0; drv_en = 1'b0; load = 1'b0; op = o; wr_sel = n;
    cyc();
    idle();
  endtask

  task automatic read_reg(input logic [1:0] n, output logic [7:0] val);
    drv_en = 1'b0; enable = 1'b1; rd_sel = n; load = 1'b1;
    #1 val = w_bus;
    enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_sel = 2'd0; rd_sel = 2'd0; drv_val = 8'h00;
    idle();
    @(negedge clk);
    cyc(); cyc();
    reset = 1'b0;
    check_eq("rst_alu_a", alu_a, 8'h00);
    check_eq("rst_alu_b", alu_b, 8'h00);
    check_eq("rst_zero", {7'd0, zero}, 8'h01);
    check_eq("rst_carry", {7'd0, carry}, 8'h00);

    // Load r2 then reset mid-sequence, with a write attempted during reset
    ext_load(2'd2, 8'h5A);
    read_reg(2'd2, v); check_eq("r2_load", v, 8'h5A);
    check_eq("r2_zero", {7'd0, zero}, 8'h00);
    reset = 1'b1; drv_en = 1'b1; drv_val = 8'h77; load = 1'b0; wr_sel = 2'd2;
    cyc();
    reset = 1'b0; idle();
    read_reg(2'd2, v); check_eq("rst_r2", v, 8'h00);
    check_eq("rst2_zero", {7'd0, zero}, 8'h01);
    check_eq("rst2_carry", {7'd0, carry}, 8'h00);

    // External load into r0
    ext_load(2'd0, 8'h3C);
    check_eq("ld_alu_a", alu_a, 8'h3C);
    check_eq("ld_zero", {7'd0, zero}, 8'h00);
    check_eq("ld_carry", {7'd0, carry}, 8'h00);
    // enable=0: DUT must not fight an external driver
    enable = 1'b0; rd_sel = 2'd0; drv_en = 1'b1; drv_val = 8'h99;
    #1 check_eq("bus_release", w_bus, 8'h99);
    idle();

    // Transfer r0 -> r3 in one edge
    drv_en = 1'b0; enable = 1'b1; rd_sel = 2'd0; load = 1'b0; op = 3'b000; wr_sel = 2'd3;
    #1 check_eq("xfer_bus", w_bus, 8'h3C);
    cyc(); idle();
    read_reg(2'd3, v); check_eq("xfer_r3", v, 8'h3C);
    check_eq("xfer_r0", alu_a, 8'h3C);

    // INC wrap and DEC borrow on r1
    ext_load(2'd1, 8'hFF);
    check_eq("r1_ff", alu_b, 8'hFF);
    do_op(3'b010, 2'd1);
    check_eq("inc_val", alu_b, 8'h00);
    check_eq("inc_zero", {7'd0, zero}, 8'h01);
    check_eq("inc_carry", {7'd0, carry}, 8'h01);
    do_op(3'b011, 2'd1);
    check_eq("dec_val", alu_b, 8'hFF);
    check_eq("dec_zero", {7'd0, zero}, 8'h00);
    check_eq("dec_carry", {7'd0, carry}, 8'h01);
    do_op(3'b010, 2'd0);
    check_eq("inc_plain", alu_a, 8'h3D);
    check_eq("inc_pcarry", {7'd0, carry}, 8'h00);
    do_op(3'b001, 2'd1);
    check_eq("clr_val", alu_b, 8'h00);
    check_eq("clr_zero", {7'd0, zero}, 8'h01);

    // Same register LOAD with enable: value unchanged, flags from value
    drv_en = 1'b0; enable = 1'b1; rd_sel = 2'd3; load = 1'b0; op = 3'b000; wr_sel = 2'd3;
    cyc(); idle();
    read_reg(2'd3, v); check_eq("self_val", v, 8'h3C);
    check_eq("self_zero", {7'd0, zero}, 8'h00);

    // Non-LOAD with enable: bus shows pre-edge value, DEC uses own value
    drv_en = 1'b0; enable = 1'b1; rd_sel = 2'd3; load = 1'b0; op = 3'b011; wr_sel = 2'd3;
    #1 check_eq("dec_bus_pre", w_bus, 8'h3C);
    cyc(); idle();
    read_reg(2'd3, v); check_eq("dec_en_val", v, 8'h3B);

    // Shift / rotate on r0
    ext_load(2'd0, 8'h81);
    do_op(3'b100, 2'd0);
`ifdef REGISTER_BANK_SHIFT_EN
    check_eq("shl_val", alu_a, 8'h02);
    check_eq("shl_carry", {7'd0, carry}, 8'h01);
`else
    check_eq("shl_hold", alu_a, 8'h81);
    check_eq("shl_chold", {7'd0, carry}, 8'h00);
`endif
    do_op(3'b111, 2'd0);
`ifdef REGISTER_BANK_SHIFT_EN
    check_eq("ror_val", alu_a, 8'h01);
    check_eq("ror_carry", {7'd0, carry}, 8'h00);
    do_op(3'b111, 2'd0);
    check_eq("ror2_val", alu_a, 8'h80);
    check_eq("ror2_carry", {7'd0, carry}, 8'h01);
    do_op(3'b101, 2'd0);
    check_eq("shr_val", alu_a, 8'h40);
    check_eq("shr_carry", {7'd0, carry}, 8'h00);
    do_op(3'b110, 2'd0);
    check_eq("rol_val", alu_a, 8'h80);
`else
    check_eq("ror_hold", alu_a, 8'h81);
    check_eq("ror_zhold", {7'd0, zero}, 8'h00);
    do_op(3'b011, 2'd1);
    check_eq("dec0_carry", {7'd0, carry}, 8'h01);
    do_op(3'b110, 2'd1);
    check_eq("rol_hold", alu_b, 8'hFF);
    check_eq("rol_chold", {7'd0, carry}, 8'h01);
`endif

    // load=1 for 10 cycles with assorted ops: nothing changes
    begin
      logic [7:0] a0, b0, r2, r3;
      logic       z0, c0;
      a0 = alu_a; b0 = alu_b; z0 = zero; c0 = carry;
      read_reg(2'd2, r2); read_reg(2'd3, r3);
      for (int i = 0; i < 10; i++) begin
        load = 1'b1; enable = 1'b0; drv_en = 1'b1; drv_val = 8'hA5;
        op = 3'(i); wr_sel = 2'(i);
        cyc();
      end
      idle();
      check_eq("hold_a", alu_a, a0);
      check_eq("hold_b", alu_b, b0);
      read_reg(2'd2, v); check_eq("hold_r2", v, r2);
      read_reg(2'd3, v); check_eq("hold_r3", v, r3);
      check_eq("hold_zero", {7'd0, zero}, {7'd0, z0});
      check_eq("hold_carry", {7'd0, carry}, {7'd0, c0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
